ksa_post_proc_pipe: RTL and testbench

KSA_POST_PROC_PIPE -- requirements
Module: KSA_post_proc_pipe

---
 rtl/ksa_post_proc_pipe.sv | 127 ++++++++++++
 tb/tb_ksa_post_proc_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ksa_post_proc_pipe.sv
// Kogge-Stone prefix tree and sum stage, pipelined behind a valid/ready handshake.
// Define KSA_PIPE_LEVEL_REG_EN to register after every prefix level (latency LEVELS+1); default latency is 1.
module ksa_post_proc_pipe #(
    parameter int SIZE_DATA = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [SIZE_DATA-1:0] i_g,
    input  logic [SIZE_DATA-1:0] i_p,
    input  logic                 i_cin,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [SIZE_DATA-1:0] o_sum,
    output logic                 o_cout,
    output logic                 o_valid,
    input  logic                 i_ready
);

    localparam int LEVELS = $clog2(SIZE_DATA);

    // Handshake: a beat is accepted on a rising edge iff i_valid & o_ready; an output
    // beat is consumed iff o_valid & i_ready. All stages shift together whenever the
    // output register is empty or being consumed, so o_ready never depends on i_valid.
    logic adv;
    assign adv     = !o_valid | i_ready;
    assign o_ready = adv;

    logic [SIZE_DATA-1:0] tg_in  [LEVELS];
    logic [SIZE_DATA-1:0] tp_in  [LEVELS];
    logic [SIZE_DATA-1:0] tg_out [LEVELS];
    logic [SIZE_DATA-1:0] tp_out [LEVELS];

    logic                 fin_v;
    logic [SIZE_DATA-1:0] fin_g;
    logic [SIZE_DATA-1:0] fin_p;
    logic [SIZE_DATA-1:0] fin_raw;
    logic                 fin_cin;

`ifdef KSA_PIPE_LEVEL_REG_EN
    // Stage j holds the result of prefix level j together with the raw p/cin of its beat.
    logic                 st_v   [LEVELS];
    logic [SIZE_DATA-1:0] st_g   [LEVELS];
    logic [SIZE_DATA-1:0] st_p   [LEVELS];
    logic [SIZE_DATA-1:0] st_raw [LEVELS];
    logic                 st_cin [LEVELS];
`endif

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int D = 1 << k;
        localparam logic [SIZE_DATA-1:0] LOW = {SIZE_DATA{1'b1}} >> (SIZE_DATA - D);

        if (k == 0) begin : g_first
            assign tg_in[k] = i_g;
            assign tp_in[k] = i_p;
        end else begin : g_next
`ifdef KSA_PIPE_LEVEL_REG_EN
            assign tg_in[k] = st_g[k-1];
            assign tp_in[k] = st_p[k-1];
`else
            assign tg_in[k] = tg_out[k-1];
            assign tp_in[k] = tp_out[k-1];
`endif
        end

        // Bits below 2^k see zero from the shift (G) or are masked high (P), so they pass through.
        assign tg_out[k] = tg_in[k] | (tp_in[k] & (tg_in[k] << D));
        assign tp_out[k] = tp_in[k] & ((tp_in[k] << D) | LOW);
    end

`ifdef KSA_PIPE_LEVEL_REG_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j < LEVELS; j++) begin
                st_v[j]   <= 1'b0;
                st_g[j]   <= '0;
                st_p[j]   <= '0;
                st_raw[j] <= '0;
                st_cin[j] <= 1'b0;
            end
        end else if (adv) begin
            st_v[0]   <= i_valid;
            st_g[0]   <= tg_out[0];
            st_p[0]   <= tp_out[0];
            st_raw[0] <= i_p;
            st_cin[0] <= i_cin;
            for (int j = 1; j < LEVELS; j++) begin
                st_v[j]   <= st_v[j-1];
                st_g[j]   <= tg_out[j];
                st_p[j]   <= tp_out[j];
                st_raw[j] <= st_raw[j-1];
                st_cin[j] <= st_cin[j-1];
            end
        end
    end

    assign fin_v   = st_v[LEVELS-1];
    assign fin_g   = st_g[LEVELS-1];
    assign fin_p   = st_p[LEVELS-1];
    assign fin_raw = st_raw[LEVELS-1];
    assign fin_cin = st_cin[LEVELS-1];
`else
    assign fin_v   = i_valid;
    assign fin_g   = tg_out[LEVELS-1];
    assign fin_p   = tp_out[LEVELS-1];
    assign fin_raw = i_p;
    assign fin_cin = i_cin;
`endif

    // Carry into bit i+1 is the group generate of [i:0] or its group propagate with cin.
    logic [SIZE_DATA-1:0] carry_hi;
    logic [SIZE_DATA:0]   carry;
    assign carry_hi = fin_g | (fin_p & {SIZE_DATA{fin_cin}});
    assign carry    = {carry_hi, fin_cin};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_cout  <= 1'b0;
        end else if (adv) begin
            o_valid <= fin_v;
            o_sum   <= fin_raw ^ carry[SIZE_DATA-1:0];
            o_cout  <= carry[SIZE_DATA];
        end
    end

endmodule

// File: tb/tb_ksa_post_proc_pipe.sv
// Directed bench for ksa_post_proc_pipe: single beats, back-to-back stream, stall and mid-stream reset.
// Build with or without KSA_PIPE_LEVEL_REG_EN; SIZE_DATA may be overridden.
module tb_ksa_post_proc_pipe;

    parameter int SIZE_DATA = 8;
    localparam int W      = SIZE_DATA;
    localparam int LEVELS = $clog2(W);
`ifdef KSA_PIPE_LEVEL_REG_EN
    localparam int N = LEVELS + 1;
`else
    localparam int N = 1;
`endif

    logic         i_clk;
    logic         i_rst_n;
    logic [W-1:0] i_g;
    logic [W-1:0] i_p;
    logic         i_cin;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] o_sum;
    logic         o_cout;
    logic         o_valid;
    logic         i_ready;

    ksa_post_proc_pipe #(.SIZE_DATA(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_g     (i_g),
        .i_p     (i_p),
        .i_cin   (i_cin),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_sum   (o_sum),
        .o_cout  (o_cout),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    logic [W:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every consumed output beat must match the oldest accepted beat
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_beat", 64'd1, 64'd0);
            end else begin
                chk("out_beat", 64'({o_cout, o_sum}), 64'(exp_q.pop_front()));
            end
        end
    end

    // driver: present a+b+cin as g/p, wait for acceptance, record expectation
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int t;
        t = 0;
        i_g     = a & b;
        i_p     = a ^ b;
        i_cin   = cin;
        i_valid = 1'b1;
        @(negedge i_clk);
        while (!o_ready && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 100) chk("accept_timeout", 64'd0, 64'd1);
        exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_g     = ~i_g;
        i_p     = ~i_p;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    logic [W-1:0] ones;
    logic [W-1:0] one;
    logic [W-1:0] p55;
    logic [W-1:0] paa;
    logic [W:0]   snap;
    int           cnt;
    int           base;

    initial begin
        ones    = '1;
        one     = W'(1);
        p55     = W'(64'h5555_5555_5555_5555);
        paa     = W'(64'hAAAA_AAAA_AAAA_AAAA);
        i_rst_n = 1'b1;
        i_g     = '0;
        i_p     = '0;
        i_cin   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;

        // reset state
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_sum",   64'(o_sum),   64'd0);
        chk("rst_cout",  64'(o_cout),  64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        repeat (2) @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // all-ones + 1: latency N, o_valid for exactly one cycle
        send(ones, one, 1'b0);
        cnt = 1;
        while (!o_valid && cnt < 40) begin
            @(posedge i_clk);
            #1;
            cnt++;
        end
        chk("lat_cycles",  64'(cnt),    64'(N));
        chk("ff01_sum",    64'(o_sum),  64'd0);
        chk("ff01_cout",   64'(o_cout), 64'd1);
        @(posedge i_clk);
        #1;
        chk("one_cycle_valid", 64'(o_valid), 64'd0);

        // alternating patterns with both carry-in values
        send(p55, paa, 1'b1);
        send(p55, paa, 1'b0);
        send(W'(3), W'(5), 1'b1);
        drain();

        // 256 back-to-back beats: output continuous once filled
        base = out_cnt;
        for (int i = 0; i < 256; i++) begin
            send(W'((64'(i) * 64'h9E37_79B9_7F4A_7C15) >> 7),
                 W'((64'(i) * 64'hC2B2_AE3D_27D4_EB4F) >> 11),
                 1'(i ^ (i >> 3)));
            if (i >= N - 1) chk("stream_cont", 64'(o_valid), 64'd1);
        end
        drain();
        chk("stream_count", 64'(out_cnt - base), 64'd256);

        // stall: fill with i_ready low, hold 5 cycles, then drain in order
        i_ready = 1'b0;
        for (int i = 0; i < N; i++) send(W'(17 * i + 9), W'(250 - 3 * i), 1'(i));
        i_g     = W'(6) & W'(10);
        i_p     = W'(6) ^ W'(10);
        i_cin   = 1'b1;
        i_valid = 1'b1;
        snap    = {o_cout, o_sum};
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk);
            #1;
            chk("stall_ready", 64'(o_ready), 64'd0);
            chk("stall_valid", 64'(o_valid), 64'd1);
            chk("stall_data",  64'({o_cout, o_sum}), 64'(snap));
        end
        i_ready = 1'b1;
        send(W'(6), W'(10), 1'b1);
        drain();

        // reset mid-stream between clock edges
        base = out_cnt;
        send(W'(21), W'(22), 1'b0);
        send(W'(33), W'(44), 1'b1);
        send(ones,   ones,   1'b1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_sum",   64'(o_sum),   64'd0);
        chk("mid_rst_cout",  64'(o_cout),  64'd0);
        chk("mid_rst_ready", 64'(o_ready), 64'd1);
        exp_q.delete();
        base = out_cnt;
        repeat (2) @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        repeat (N + 3) @(posedge i_clk);
        #1;
        chk("no_stale_beat", 64'(out_cnt - base), 64'd0);
        send(W'(100), W'(27), 1'b1);
        drain();
        chk("resume_count", 64'(out_cnt - base), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
